imul_iterative: RTL and testbench

//  Iterative shift-and-add multiplier with val/rdy stream handshakes on input and output.

---
 rtl/imul_pkg.sv | 15 +
 rtl/imul_dpath.sv | 89 ++++++++
 rtl/imul_iterative.sv | 91 +++++++++
 tb/tb_imul_iterative.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/imul_pkg.sv
// Shared types and sizing helpers for the iterative multiplier.
// The FSM encoding and the iteration-counter width live here.
package imul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_w(input int w);
    return ($clog2(w) < 1) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/imul_dpath.sv
// Datapath of the shift-and-add multiplier.
// Holds the operand/result registers, sign handling, adder and shifters.
module imul_dpath
  import imul_pkg::*;
#(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           load,
  input  logic           step,
  input  logic           add_en,
  input  logic           fin,
  input  logic [2*W-1:0] msg,
  input  logic           sgn,
  output logic           b_lsb,
  output logic           b_rest_zero,
  output logic           cnt_last,
  output logic [2*W-1:0] result
);

  localparam int CW = cnt_w(W);

  logic [2*W-1:0] a_r;
  logic [2*W-1:0] r_r;
  logic [W-1:0]   b_r;
  logic [CW-1:0]  cnt_r;
  logic           neg_r;

  logic [W-1:0]   a_op_s;
  logic [W-1:0]   b_op_s;
  logic [2*W-1:0] sum_s;
  logic [2*W-1:0] final_s;

  // The most negative value maps onto 2^(W-1), which still fits as an unsigned W-bit magnitude.
  function automatic logic [W-1:0] magnitude(input logic [W-1:0] x, input logic s);
    if (s && x[W-1]) begin
      return ~x + {{(W-1){1'b0}}, 1'b1};
    end else begin
      return x;
    end
  endfunction

  assign a_op_s      = msg[2*W-1:W];
  assign b_op_s      = msg[W-1:0];
  assign b_lsb       = b_r[0];
  assign b_rest_zero = (b_r[W-1:1] == {(W-1){1'b0}});
  assign cnt_last    = (cnt_r == CW'(W - 1));
  assign result      = r_r;

  // Partial-sum adder plus the optional final two's-complement negation.
  always_comb begin
    sum_s   = r_r;
    final_s = r_r;
    if (add_en) begin
      sum_s = r_r + a_r;
    end else begin
      sum_s = r_r;
    end
    if (neg_r) begin
      final_s = ~sum_s + {{(2*W-1){1'b0}}, 1'b1};
    end else begin
      final_s = sum_s;
    end
  end

  // Operand capture on accept, then one shift/accumulate step per CALC cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_r   <= {(2*W){1'b0}};
      b_r   <= {W{1'b0}};
      r_r   <= {(2*W){1'b0}};
      cnt_r <= {CW{1'b0}};
      neg_r <= 1'b0;
    end else if (load) begin
      a_r   <= {{W{1'b0}}, magnitude(a_op_s, sgn)};
      b_r   <= magnitude(b_op_s, sgn);
      r_r   <= {(2*W){1'b0}};
      cnt_r <= {CW{1'b0}};
      neg_r <= sgn & (a_op_s[W-1] ^ b_op_s[W-1]);
    end else if (step) begin
      r_r   <= fin ? final_s : sum_s;
      a_r   <= a_r << 1;
      b_r   <= b_r >> 1;
      cnt_r <= cnt_r + CW'(1);
    end
  end

endmodule

// File: rtl/imul_iterative.sv
// Multi-cycle MUL unit: val/rdy wrapper and control FSM around imul_dpath.
// One transaction in flight; the product is held until the consumer takes it.
module imul_iterative
  import imul_pkg::*;
#(
  parameter int W          = 32,
  parameter int EARLY_TERM = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           istream_val,
  output logic           istream_rdy,
  input  logic [2*W-1:0] istream_msg,
  input  logic           istream_sgn,
  output logic           ostream_val,
  input  logic           ostream_rdy,
  output logic [2*W-1:0] ostream_msg
);

  state_t state_r;

  logic load_s;
  logic step_s;
  logic add_en_s;
  logic done_s;
  logic fin_s;
  logic b_lsb_s;
  logic b_rest_zero_s;
  logic cnt_last_s;

  // An iteration is the last one at the top bit position, or once no multiplier bits remain.
  always_comb begin
    load_s   = istream_val && istream_rdy;
    step_s   = (state_r == CALC);
    add_en_s = step_s && b_lsb_s;
    done_s   = cnt_last_s || ((EARLY_TERM != 0) && b_rest_zero_s);
    fin_s    = step_s && done_s;
  end

  imul_dpath #(.W(W)) u_dpath (
    .clk         (clk),
    .reset       (reset),
    .load        (load_s),
    .step        (step_s),
    .add_en      (add_en_s),
    .fin         (fin_s),
    .msg         (istream_msg),
    .sgn         (istream_sgn),
    .b_lsb       (b_lsb_s),
    .b_rest_zero (b_rest_zero_s),
    .cnt_last    (cnt_last_s),
    .result      (ostream_msg)
  );

  // Control FSM with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      istream_rdy <= 1'b1;
      ostream_val <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (istream_val) begin
            state_r     <= CALC;
            istream_rdy <= 1'b0;
          end
        end
        CALC: begin
          if (done_s) begin
            state_r     <= DONE;
            ostream_val <= 1'b1;
          end
        end
        DONE: begin
          if (ostream_rdy) begin
            state_r     <= IDLE;
            ostream_val <= 1'b0;
            istream_rdy <= 1'b1;
          end
        end
        default: begin
          state_r     <= IDLE;
          istream_rdy <= 1'b1;
          ostream_val <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imul_iterative.sv
// Self-checking bench for imul_iterative (W=32, EARLY_TERM=1).
// Products come from plain 64-bit arithmetic; latency from the magnitude's top set bit.
module tb_imul_iterative;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          istream_val;
  logic          istream_rdy;
  logic [63:0]   istream_msg;
  logic          istream_sgn;
  logic          ostream_val;
  logic          ostream_rdy;
  logic [63:0]   ostream_msg;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  imul_iterative #(.W(W), .EARLY_TERM(1)) dut (
    .clk         (clk),
    .reset       (reset),
    .istream_val (istream_val),
    .istream_rdy (istream_rdy),
    .istream_msg (istream_msg),
    .istream_sgn (istream_sgn),
    .ostream_val (ostream_val),
    .ostream_rdy (ostream_rdy),
    .ostream_msg (ostream_msg)
  );

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa, sb;
    if (s) begin
      sa = longint'(signed'(a));
      sb = longint'(signed'(b));
    end else begin
      sa = longint'({32'h0, a});
      sb = longint'({32'h0, b});
    end
    return 64'(sa * sb);
  endfunction

  // Cycles from the accept edge to the edge that raises ostream_val.
  function automatic int ref_lat(input logic [31:0] b, input logic s);
    logic [31:0] mag;
    mag = (s && b[31]) ? (32'h0 - b) : b;
    for (int i = 31; i >= 0; i--) begin
      if (mag[i]) return i + 1;
    end
    return 1;
  endfunction

  // Full transaction; all driving and sampling happens on the falling edge.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s, input bit rnd,
                       output logic [63:0] prod, output int lat, output bit ok);
    int g;
    ok = 1'b1;
    g = 0;
    while (!istream_rdy && g < 100) begin
      @(negedge clk);
      g++;
    end
    istream_val = 1'b1;
    istream_msg = {a, b};
    istream_sgn = s;
    @(negedge clk);
    istream_val = 1'b0;
    istream_msg = {$urandom, $urandom};
    istream_sgn = 1'($urandom_range(0, 1));
    lat = 0;
    while (!ostream_val && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (!ostream_val) ok = 1'b0;
    prod = ostream_msg;
    ostream_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    g = 0;
    while (!ostream_rdy && g < 50) begin
      @(negedge clk);
      if (ostream_msg !== prod || ostream_val !== 1'b1) ok = 1'b0;
      ostream_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      g++;
    end
    ostream_rdy = 1'b1;
    @(negedge clk);
    ostream_rdy = 1'b0;
    if (ostream_val !== 1'b0 || istream_rdy !== 1'b1) ok = 1'b0;
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    istream_val = 1'b1;
    istream_msg = 64'h0000_0003_0000_0005;
    istream_sgn = 1'b0;
    ostream_rdy = 1'b0;
    repeat (3) @(negedge clk);
    reset       = 1'b0;
    istream_val = 1'b0;
    total_cnt++;
    if (istream_rdy !== 1'b1 || ostream_val !== 1'b0 || ostream_msg !== 64'h0)
      $display("FAIL reset: rdy=%b val=%b msg=%h required rdy=1 val=0 msg=0",
               istream_rdy, ostream_val, ostream_msg);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    logic [63:0] p; int lat; bit ok;
    do_op(32'd3, 32'd5, 1'b0, 1'b0, p, lat, ok);
    total_cnt++;
    if (ok !== 1'b1 || p !== 64'h0000_0000_0000_000F)
      $display("FAIL basic_3x5: got %h ok=%b required 000000000000000f", p, ok);
    else pass_cnt++;
    total_cnt++;
    if (lat !== 3) $display("FAIL basic_latency: got %0d required 3", lat);
    else pass_cnt++;
  endtask

  task automatic test_signed();
    logic [63:0] p; int lat; bit ok;
    do_op(32'hFFFF_FFFD, 32'd5, 1'b1, 1'b0, p, lat, ok);
    total_cnt++;
    if (ok !== 1'b1 || p !== 64'hFFFF_FFFF_FFFF_FFF1)
      $display("FAIL signed_m3x5: got %h ok=%b required fffffffffffffff1", p, ok);
    else pass_cnt++;
    do_op(32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0, p, lat, ok);
    total_cnt++;
    if (ok !== 1'b1 || p !== 64'h0000_0004_FFFF_FFF1)
      $display("FAIL unsigned_m3x5: got %h ok=%b required 00000004fffffff1", p, ok);
    else pass_cnt++;
  endtask

  task automatic test_extremes();
    logic [63:0] p; int lat; bit ok;
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, p, lat, ok);
    total_cnt++;
    if (ok !== 1'b1 || p !== 64'hFFFF_FFFE_0000_0001)
      $display("FAIL max_unsigned: got %h ok=%b required fffffffe00000001", p, ok);
    else pass_cnt++;
    total_cnt++;
    if (lat !== 32) $display("FAIL max_latency: got %0d required 32", lat);
    else pass_cnt++;
    do_op(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, p, lat, ok);
    total_cnt++;
    if (ok !== 1'b1 || p !== 64'h4000_0000_0000_0000)
      $display("FAIL min_signed: got %h ok=%b required 4000000000000000", p, ok);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    logic [63:0] p; int lat; bit ok; int g;
    istream_val = 1'b1;
    istream_msg = {32'd11, 32'd13};
    istream_sgn = 1'b0;
    ostream_rdy = 1'b0;
    @(negedge clk);
    istream_val = 1'b0;
    g = 0;
    while (!ostream_val && g < 100) begin
      @(negedge clk);
      g++;
    end
    for (int i = 0; i < 10; i++) begin
      istream_val = 1'b1;
      istream_msg = {32'd100, 32'd200};
      total_cnt++;
      if (ostream_val !== 1'b1 || ostream_msg !== 64'd143 || istream_rdy !== 1'b0)
        $display("FAIL bp_hold%0d: val=%b msg=%h rdy=%b required val=1 msg=%h rdy=0",
                 i, ostream_val, ostream_msg, istream_rdy, 64'd143);
      else pass_cnt++;
      @(negedge clk);
    end
    ostream_rdy = 1'b1;
    @(negedge clk);
    ostream_rdy = 1'b0;
    total_cnt++;
    if (ostream_val !== 1'b0 || istream_rdy !== 1'b1)
      $display("FAIL bp_release: val=%b rdy=%b required val=0 rdy=1", ostream_val, istream_rdy);
    else pass_cnt++;
    // istream_val is still high, so the held request is taken now.
    do_op(32'd100, 32'd200, 1'b0, 1'b0, p, lat, ok);
    total_cnt++;
    if (ok !== 1'b1 || p !== 64'd20000)
      $display("FAIL bp_next: got %h ok=%b required %h", p, ok, 64'd20000);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_calc();
    logic [63:0] p; int lat; bit ok;
    istream_val = 1'b1;
    istream_msg = {32'h1234_5678, 32'hFFFF_FFFF};
    istream_sgn = 1'b0;
    @(negedge clk);
    istream_val = 1'b0;
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total_cnt++;
    if (istream_rdy !== 1'b1 || ostream_val !== 1'b0 || ostream_msg !== 64'h0)
      $display("FAIL mid_reset: rdy=%b val=%b msg=%h required rdy=1 val=0 msg=0",
               istream_rdy, ostream_val, ostream_msg);
    else pass_cnt++;
    do_op(32'd7, 32'd6, 1'b0, 1'b0, p, lat, ok);
    total_cnt++;
    if (ok !== 1'b1 || p !== 64'd42)
      $display("FAIL after_reset_7x6: got %h ok=%b required %h", p, ok, 64'd42);
    else pass_cnt++;
  endtask

  task automatic test_zero();
    logic [63:0] p; int lat; bit ok;
    do_op(32'hDEAD_BEEF, 32'd0, 1'b1, 1'b0, p, lat, ok);
    total_cnt++;
    if (ok !== 1'b1 || p !== 64'h0 || lat !== 1)
      $display("FAIL zero_b: got %h lat=%0d ok=%b required 0 lat=1", p, lat, ok);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [63:0] p; int lat; bit ok;
    logic [31:0] a, b; logic s;
    int bad = 0;
    for (int i = 0; i < 1000; i++) begin
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 1) == 0) b = b >> $urandom_range(0, 31);
      s = 1'($urandom_range(0, 1));
      do_op(a, b, s, 1'b1, p, lat, ok);
      total_cnt++;
      if (ok !== 1'b1 || p !== ref_mul(a, b, s) || lat !== ref_lat(b, s)) begin
        if (bad < 10)
          $display("FAIL random%0d: a=%h b=%h sgn=%b got %h lat=%0d ok=%b required %h lat=%0d",
                   i, a, b, s, p, lat, ok, ref_mul(a, b, s), ref_lat(b, s));
        bad++;
      end else pass_cnt++;
    end
  endtask

  initial begin
    reset       = 1'b1;
    istream_val = 1'b0;
    istream_msg = 64'h0;
    istream_sgn = 1'b0;
    ostream_rdy = 1'b0;
    test_reset();
    test_basic();
    test_signed();
    test_extremes();
    test_backpressure();
    test_reset_mid_calc();
    test_zero();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
